// File: rtl/video_pattern_generator_pkg.sv
// Shared video timing constants, pattern encodings and the per-pixel pattern function
// used by the pattern generator and its bench.
package video_pattern_generator_pkg;

  localparam int H_DISPLAY_DEFAULT = 640;
  localparam int V_DISPLAY_DEFAULT = 480;
  localparam int RGB_W             = 3;

  typedef enum logic [1:0] {
    PAT_BARS   = 2'd0,
    PAT_CHECK  = 2'd1,
    PAT_GRID   = 2'd2,
    PAT_SCROLL = 2'd3
  } pattern_e;

  function automatic logic [RGB_W-1:0] pattern_pixel(
    input pattern_e   pat,
    input logic [9:0] hpos,
    input logic [9:0] vpos,
    input logic [7:0] frame_cnt,
    input logic [9:0] h_last,
    input logic [9:0] v_last
  );
    logic [RGB_W-1:0] pix;
    pix = '0;
    case (pat)
      PAT_BARS:  pix = hpos[8:6];
      PAT_CHECK: pix = {RGB_W{hpos[5] ^ vpos[5]}};
      PAT_GRID:  pix = ((hpos[4:0] == 5'd0) || (vpos[4:0] == 5'd0) ||
                        (hpos == h_last) || (vpos == v_last)) ? '1 : '0;
      // 10-bit sum wraps modulo 1024 before the bar index is taken
      PAT_SCROLL: pix = RGB_W'(({2'b00, frame_cnt} + hpos) >> 6);
      default:   pix = '0;
    endcase
    return pix;
  endfunction

endpackage

// File: rtl/video_pattern_generator_if.sv
// Pixel bus between the sync generator and the pattern generator.
// master drives timing and reads the pins; slave is the pattern stage.
interface video_pattern_generator_if;
  import video_pattern_generator_pkg::*;

  logic [9:0]       hpos;
  logic [9:0]       vpos;
  logic             display_on;
  logic             hsync_in;
  logic             vsync_in;
  logic [RGB_W-1:0] rgb;
  logic             hsync;
  logic             vsync;
  logic [1:0]       mode;

  modport master (
    output hpos, vpos, display_on, hsync_in, vsync_in,
    input  rgb, hsync, vsync, mode
  );

  modport slave (
    input  hpos, vpos, display_on, hsync_in, vsync_in,
    output rgb, hsync, vsync, mode
  );
endinterface

// File: rtl/video_pattern_generator_button_debouncer.sv
// Raw push-button to single-cycle press pulse: 2-FF synchroniser, hold-time
// debouncer and rising-edge detect on the accepted level.
module button_debouncer
  import video_pattern_generator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_comb begin
    accept   = (sync2_q != stable_q) && (cnt_q == CNT_LAST);
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (accept) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Pulse coincides with the edge that flips the accepted level to 1.
  assign press_o = accept & sync2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/video_pattern_generator.sv
// Pixel stage after the sync generator: test-pattern mux, frame-tick detect,
// button-selected mode applied at frame start, and one-cycle output register.
module video_pattern_generator
  import video_pattern_generator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int H_DISPLAY       = H_DISPLAY_DEFAULT,
  parameter int V_DISPLAY       = V_DISPLAY_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        btn,
  video_pattern_generator_if.slave    vid
);

  localparam logic [9:0] H_LAST = 10'(H_DISPLAY - 1);
  localparam logic [9:0] V_LAST = 10'(V_DISPLAY - 1);

  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             hsync_q, vsync_q;
  logic             vsync_prev_q;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       pending_q, pending_d;
  logic [7:0]       frame_q, frame_d;
  logic             frame_tick;
  logic             press;
  logic [RGB_W-1:0] pix;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk_i  (clk),
    .rst_ni (reset),
    .btn_i  (btn),
    .press_o(press)
  );

  always_comb begin
    frame_tick = vid.vsync_in & ~vsync_prev_q;
    pix        = pattern_pixel(pattern_e'(mode_q), vid.hpos, vid.vpos, frame_q, H_LAST, V_LAST);
    rgb_d      = vid.display_on ? pix : '0;
    // A press on the tick edge lands in pending only after mode has sampled it.
    mode_d     = frame_tick ? pending_q : mode_q;
    pending_d  = press ? pending_q + 2'd1 : pending_q;
    frame_d    = frame_tick ? frame_q + 8'd1 : frame_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rgb_q        <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      vsync_prev_q <= 1'b1;
      mode_q       <= '0;
      pending_q    <= '0;
      frame_q      <= '0;
    end else begin
      rgb_q        <= rgb_d;
      hsync_q      <= vid.hsync_in;
      vsync_q      <= vid.vsync_in;
      vsync_prev_q <= vid.vsync_in;
      mode_q       <= mode_d;
      pending_q    <= pending_d;
      frame_q      <= frame_d;
    end
  end

  assign vid.rgb   = rgb_q;
  assign vid.hsync = hsync_q;
  assign vid.vsync = vsync_q;
  assign vid.mode  = mode_q;

endmodule

// File: tb/tb_video_pattern_generator.sv
// Scoreboard bench for video_pattern_generator with a behavioural reference model.
module tb_video_pattern_generator;
  import video_pattern_generator_pkg::*;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn = 1'b0;

  video_pattern_generator_if vif ();

  video_pattern_generator #(
    .DEBOUNCE_CYCLES(DEB),
    .H_DISPLAY      (640),
    .V_DISPLAY      (480)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .btn  (btn),
    .vid  (vif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
    logic [1:0] mode;
  } exp_t;

  exp_t exp_q[$];
  int pass_cnt  = 0;
  int check_cnt = 0;

  // Reference model state
  int m_mode = 0, m_pend = 0, m_frame = 0, m_vprev = 1;
  int m_s1 = 0, m_s2 = 0, m_acc = 0, m_run = 0;

  function automatic int ref_pixel(input int mode, input int h, input int v, input int fr);
    case (mode)
      0:       return (h / 64) % 8;
      1:       return (((h / 32) % 2) != ((v / 32) % 2)) ? 7 : 0;
      2:       return (h % 32 == 0 || v % 32 == 0 || h == 639 || v == 479) ? 7 : 0;
      default: return (((h + fr) % 1024) / 64) % 8;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    check_cnt++;
    if (act == expv) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input bit rst, input int h, input int v, input bit de,
                      input bit hs, input bit vs, input bit b);
    exp_t e;
    bit   tick;
    bit   press;
    int   pix;
    @(negedge clk);
    reset          = rst;
    vif.hpos       = 10'(h);
    vif.vpos       = 10'(v);
    vif.display_on = de;
    vif.hsync_in   = hs;
    vif.vsync_in   = vs;
    btn            = b;
    if (!rst) begin
      m_mode = 0; m_pend = 0; m_frame = 0; m_vprev = 1;
      m_s1 = 0; m_s2 = 0; m_acc = 0; m_run = 0;
      e.rgb = 3'd0; e.hs = 1'b0; e.vs = 1'b0; e.mode = 2'd0;
    end else begin
      tick  = vs && (m_vprev == 0);
      pix   = de ? ref_pixel(m_mode, h, v, m_frame) : 0;
      press = 1'b0;
      // accepted level follows the synchronised button once it has disagreed DEB cycles in a row
      if (m_s2 != m_acc) begin
        if (m_run == DEB - 1) begin
          m_acc = m_s2;
          m_run = 0;
          press = (m_acc == 1);
        end else begin
          m_run++;
        end
      end else begin
        m_run = 0;
      end
      if (tick) begin
        m_mode  = m_pend;
        m_frame = (m_frame + 1) % 256;
      end
      if (press) m_pend = (m_pend + 1) % 4;
      m_vprev = vs;
      m_s2    = m_s1;
      m_s1    = b;
      e.rgb = 3'(pix); e.hs = hs; e.vs = vs; e.mode = 2'(m_mode);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit b);
    for (int i = 0; i < n; i++) step(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, b);
  endtask

  task automatic tick_frame();
    step(1'b1, 5, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5, 5, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic press_btn();
    idle(8, 1'b1);
    idle(8, 1'b0);
  endtask

  task automatic set_mode(input int target);
    for (int i = 0; i < 4 && m_pend != target; i++) press_btn();
    tick_frame();
  endtask

  // Monitor: outputs are valid every cycle, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rgb",   int'(vif.rgb),   int'(e.rgb));
      chk("hsync", int'(vif.hsync), int'(e.hs));
      chk("vsync", int'(vif.vsync), int'(e.vs));
      chk("mode",  int'(vif.mode),  int'(e.mode));
    end
  end

  initial begin
    int  h, v, hold, lp;
    bit  rb, de, hs, vs, rst;
    vif.hpos = '0; vif.vpos = '0; vif.display_on = 1'b0;
    vif.hsync_in = 1'b0; vif.vsync_in = 1'b1;

    // Reset with vsync high, then release while vsync stays high
    repeat (3) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);

    // Mode 0 pixels, blanking, sync pass-through
    step(1'b1, 130, 10, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 130, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 511, 300, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Short glitch ignored, long hold accepted, applied only at the tick
    idle(2, 1'b1);
    idle(10, 1'b0);
    tick_frame();
    idle(10, 1'b1);
    idle(8, 1'b0);
    step(1'b1, 200, 40, 1'b1, 1'b0, 1'b0, 1'b0);
    tick_frame();
    step(1'b1, 200, 40, 1'b1, 1'b0, 1'b0, 1'b0);

    // Press on the same edge as the frame tick
    idle(5, 1'b1);
    step(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(8, 1'b0);
    tick_frame();

    // Four presses in one frame wrap back
    repeat (4) press_btn();
    tick_frame();

    // Grid borders
    set_mode(2);
    step(1'b1, 32, 100, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 33, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 639, 200, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 100, 479, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 100, 64, 1'b1, 1'b0, 1'b0, 1'b0);

    // Scroll across frame-counter values and wrap
    set_mode(3);
    for (lp = 0; lp < 300 && m_frame != 70; lp++) tick_frame();
    step(1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (lp = 0; lp < 300 && m_frame != 0; lp++) tick_frame();
    step(1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (lp = 0; lp < 300 && m_frame != 100; lp++) tick_frame();
    step(1'b1, 1000, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 923, 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomised traffic with a mid-frame reset
    hold = 0; rb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      h = $urandom_range(799);
      v = $urandom_range(524);
      if ($urandom_range(3) == 0) h = 32 * $urandom_range(19);
      if (hold == 0) begin
        rb   = 1'($urandom_range(1));
        hold = $urandom_range(12, 1);
      end
      hold--;
      vs  = (i % 24) >= 20;
      hs  = (h >= 656) && (h < 752);
      de  = (h < 640) && (v < 480);
      rst = (i != 1500);
      step(rst, h, v, de, hs, vs, rb);
    end

    // Drain the scoreboard within a bounded number of cycles
    for (lp = 0; lp < 10 && exp_q.size() > 0; lp++) @(posedge clk);
    #2;
    check_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
